// File: rtl/rv32imf_irq_arbiter.sv
// Interrupt arbiter: synchronises raw lines, latches edge sources, picks the
// highest-priority eligible source and hands it to the controller.
module rv32imf_irq_arbiter #(
  parameter  int NUM_IRQ     = 32,
  parameter  int PRIO_W      = 3,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = $clog2(NUM_IRQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IRQ-1:0]       irq_i,
  input  logic [NUM_IRQ-1:0]       edge_mode_i,
  input  logic [NUM_IRQ-1:0]       ie_i,
  input  logic [NUM_IRQ*PRIO_W-1:0] prio_i,
  input  logic [PRIO_W-1:0]        threshold_i,
  input  logic                     m_ie_i,
  output logic                     irq_req_o,
  output logic [ID_W-1:0]          irq_id_o,
  output logic [PRIO_W-1:0]        irq_prio_o,
  input  logic                     irq_ack_i,
  input  logic                     irq_done_i,
  input  logic [ID_W-1:0]          irq_done_id_i,
  output logic                     busy_o,
  output logic [NUM_IRQ-1:0]       pending_o,
  output logic                     wu_o,
  output logic [1:0]               state_o
);

  localparam int NUM_PAD = 1 << ID_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] s_d_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_PAD-1:0] elig_pad;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic [PRIO_W-1:0]  win_prio;
  logic               ack_take;

  state_e             state_q;
  logic               req_q;
  logic [ID_W-1:0]    id_q;
  logic [PRIO_W-1:0]  prio_q;
  logic               busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_d_q     <= '0;
      pending_q <= '0;
    end else begin
      sync_q[0] <= irq_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_d_q     <= s;
      pending_q <= pending_d;
    end
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign ack_take = (state_q == ST_REQ) && irq_ack_i;
  assign clr      = ack_take ? (NUM_IRQ'(1) << id_q) : '0;

  // Edge sources: a new rising edge wins over a same-cycle claim clear.
  always_comb begin
    pending_d = (edge_mode_i & ((pending_q & ~clr) | (s & ~s_d_q)))
              | (~edge_mode_i & s);
  end

  // Ties resolve to the higher index because later sources win on equality.
  always_comb begin
    eligible  = '0;
    win_valid = 1'b0;
    win_id    = '0;
    win_prio  = '0;
    for (int n = 0; n < NUM_IRQ; n++) begin
      eligible[n] = pending_q[n] & ie_i[n] & (prio_i[n*PRIO_W +: PRIO_W] > threshold_i);
      if (eligible[n] && (!win_valid || (prio_i[n*PRIO_W +: PRIO_W] >= win_prio))) begin
        win_valid = 1'b1;
        win_id    = ID_W'(n);
        win_prio  = prio_i[n*PRIO_W +: PRIO_W];
      end
    end
  end

  assign elig_pad = NUM_PAD'(eligible);

  // Handshake: irq_req_o stays high with a frozen id/prio until the controller
  // pulses irq_ack_i (claim) or the source loses eligibility (withdraw); a claim
  // in the same cycle as a withdraw condition is honoured. The claimed source
  // stays in service until irq_done_i arrives carrying the matching id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      id_q    <= '0;
      prio_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m_ie_i && win_valid) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            id_q    <= win_id;
            prio_q  <= win_prio;
          end
        end
        ST_REQ: begin
          if (irq_ack_i) begin
            state_q <= ST_ACTIVE;
            req_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else if (!elig_pad[id_q] || !m_ie_i) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (irq_done_i && (irq_done_id_i == id_q)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req_o  = req_q;
  assign irq_id_o   = id_q;
  assign irq_prio_o = prio_q;
  assign busy_o     = busy_q;
  assign pending_o  = pending_q;
  assign wu_o       = |(pending_q & ie_i);
  assign state_o    = state_q;

endmodule

// File: doc/rv32imf_irq_arbiter.md
# rv32imf_irq_arbiter

Parametrised interrupt arbiter for the rv32imf core. It samples NUM_IRQ asynchronous interrupt lines through a configurable synchroniser and latches edge-mode sources. It selects the highest-priority enabled source above a programmable threshold, then presents it to the core controller through a request/acknowledge/complete handshake. It sits between the external interrupt pins and the controller, and it adds per-source mode, per-source priority and in-service tracking.

## Interface
- NUM_IRQ, 32, number of interrupt sources (2..64)
- PRIO_W, 3, width of each priority field
- SYNC_STAGES, 2, synchroniser flops per input (≥1)
- ID_W, $clog2(NUM_IRQ), derived, not overridable
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- irq_i  in  NUM_IRQ  raw interrupt lines, asynchronous
- edge_mode_i  in  NUM_IRQ  per source: 1 = rising-edge latched, 0 = level
- ie_i  in  NUM_IRQ  per-source enable
- prio_i  in  NUM_IRQ*PRIO_W  priority of source n at [n*PRIO_W +: PRIO_W]
- threshold_i  in  PRIO_W  source eligible only if prio > threshold
- m_ie_i  in  1  global enable
- irq_req_o  out  1  request to controller, registered
- irq_id_o  out  ID_W  requested/in-service source ID, registered
- irq_prio_o  out  PRIO_W  priority of irq_id_o, registered
- irq_ack_i  in  1  controller claims the current request
- irq_done_i  in  1  handler completion strobe
- irq_done_id_i  in  ID_W  ID being completed
- busy_o  out  1  a source is in service
- pending_o  out  NUM_IRQ  pending register, mip-style view
- wu_o  out  1  wake-up: |(pending_o & ie_i), combinational, ignores m_ie_i and threshold

## Operation
- Sync: each irq_i[n] passes through SYNC_STAGES flops, giving s[n]; s_d[n] is s[n] delayed by one cycle.
- Pending register p[n], updated every cycle:
  - level source: p ← s
  - edge source: p ← (p & ~clr) | (s & ~s_d)
  - clr[n] = ack accepted for ID n this cycle. Set beats clear when both occur in the same cycle.
- Eligible: e[n] = p[n] & ie_i[n] & (prio[n] > threshold_i).
- Winner: the eligible source with maximum prio. Ties go to the higher index. No eligible source means no winner.
- FSM states IDLE, REQ, ACTIVE:
  - IDLE: if m_ie_i and a winner exists → REQ. irq_id_o/irq_prio_o load the winner and irq_req_o=1.
  - REQ: ID and prio are frozen; no re-arbitration even if a higher-priority source appears.
    - irq_ack_i=1 → ACTIVE, irq_req_o=0, busy_o=1, edge pending of the ID cleared.
    - Otherwise, if the frozen ID is no longer eligible or m_ie_i=0 → withdraw: IDLE, irq_req_o=0.
    - Ack takes precedence over withdraw in the same cycle.
  - ACTIVE: irq_id_o keeps the in-service ID. irq_done_i with irq_done_id_i == irq_id_o → IDLE, busy_o=0. A done with a mismatched ID is ignored.
- irq_ack_i outside REQ and irq_done_i outside ACTIVE are ignored.
- Edge re-arriving for the in-service ID during ACTIVE is latched and requested again after done. A level source still high after done is re-requested.
- Source IDs ≥ NUM_IRQ are never produced.

## Timing
- Reset: all sync flops, s_d and p are 0. FSM=IDLE. irq_req_o=0, irq_id_o=0, irq_prio_o=0, busy_o=0, pending_o=0, wu_o=0.
- Latency, with irq_i high before edge k:
  - s valid after edge k+SYNC_STAGES-1
  - p set after edge k+SYNC_STAGES
  - irq_req_o high after edge k+SYNC_STAGES+1 (SYNC_STAGES=2: 4th edge)
- Edge pulses shorter than one clk period may be missed. Callers must hold edge inputs high for at least 2 cycles.
- Ack at edge j: irq_req_o=0 and busy_o=1 after edge j.
- Done at edge j: IDLE after edge j; the earliest next request is after edge j+1.
- Withdraw: irq_req_o drops one edge after loss of eligibility.
- rst_n asserted mid-operation forces the reset state immediately, including ACTIVE. Latched edges are lost.

## Test plan
- Level source 5, prio 3, threshold 0, ie/m_ie=1: raise irq_i[5] → irq_req_o=1, id=5, prio=3 after 4 edges. Ack → busy_o=1. Done id 5 → IDLE, then re-request since the line is still high.
- Sources 3 and 7 raised together at prio 2; then source 3 alone at prio 4 → id=7 in the first case (tie, higher index), id=3 in the second.
- Edge source 9: 2-cycle pulse → pending_o[9]=1 stays set after the line falls. Ack clears it. A second pulse during ACTIVE → pending again; after done id 9, req with id=9.
- Level source 4 in REQ drops before ack → irq_req_o=0 one edge later, FSM IDLE, no busy_o. Repeat with m_ie_i dropped instead → same withdraw.
- Threshold=3, source 2 at prio 3 → no req, but wu_o=1. Threshold=2 → req id=2. Done with id 6 while source 2 is active → ignored, busy_o stays 1.
- rst_n pulse while ACTIVE with a latched edge → every output is 0 asynchronously, pending_o=0, and there is no request after release until a new edge.
